// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

  localparam logic [DEF_DIVIDEND_W-1:0] DBZ_QUOTIENT  = '1;
  localparam logic [DEF_DIVISOR_W-1:0]  DBZ_REMAINDER = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  // r_in < divisor always holds, so its MSB is zero; keeping it in the compare
  // leaves the result identical while every input bit stays in use.
  logic [DIVISOR_W+1:0] trial;

  assign trial = {r_in, bit_in};
  assign q_bit = (trial >= {2'b00, divisor});
  assign r_out = q_bit ? (trial[DIVISOR_W:0] - {1'b0, divisor}) : trial[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | one restoring step per cycle, DIVIDEND_W steps
// DONE  | out_valid high, result held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  div_state_t state, state_next;

  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    rem_step;
  logic                  q_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in    (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .r_out   (rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt_q == LAST_STEP) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
            dbz_q <= (divisor == '0);
            if (divisor == '0) begin
              quo_q <= {DIVIDEND_W{1'b1}};
              rem_q <= {1'b0, {DIVISOR_W{1'b1}}};
            end else begin
              quo_q <= '0;
              rem_q <= '0;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_step;
          quo_q <= {quo_q[DIVIDEND_W-2:0], q_bit};
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q[DIVISOR_W-1:0];
  assign div_by_zero = dbz_q;

endmodule
